// File: rtl/axi3_wr_slave_mem.sv
// AXI3 write-only slave: FIXED/INCR/WRAP beat addressing into a local 32-bit memory, one B per burst.
// Optional protocol checking with SLVERR response is enabled by defining AXI3_WR_SLAVE_CHK_EN.
module axi3_wr_slave_mem #(
    parameter int ID_W   = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       S_AXI_AWADDR,
    input  logic [ID_W-1:0]   S_AXI_AWID,
    input  logic [1:0]        S_AXI_AWBURST,
    input  logic [3:0]        S_AXI_AWLEN,
    input  logic [2:0]        S_AXI_AWSIZE,
    input  logic [1:0]        S_AXI_AWLOCK,
    input  logic [3:0]        S_AXI_AWCACHE,
    input  logic [2:0]        S_AXI_AWPROT,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [6:0]        S_AXI_WID,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WLAST,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [ID_W-1:0]   S_AXI_BID,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);
    localparam int AW = MEM_AW + 2;
    localparam logic [AW-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] id;
    logic [1:0]      burst;
    logic [3:0]      len;
    logic [2:0]      size;
    logic [AW-1:0]   addr;
    logic [3:0]      beat_cnt;
    logic            err;
    logic [31:0]     mem [2**MEM_AW];

    logic [AW-1:0]   inc, bnd, addr_nxt;
    logic            last_beat, beat_fire, aw_err, beat_err, we;

    always_comb begin
        inc       = ONE << size;
        bnd       = AW'({1'b0, len} + 5'd1) << size;
        last_beat = (beat_cnt == len);
        beat_fire = (state == DATA) && S_AXI_WREADY && S_AXI_WVALID;
        case (burst)
            2'b00:   addr_nxt = addr;
            2'b10:   addr_nxt = (addr & ~(bnd - ONE)) | ((addr + inc) & (bnd - ONE));
            default: addr_nxt = addr + inc;
        endcase
`ifdef AXI3_WR_SLAVE_CHK_EN
        aw_err   = (S_AXI_AWSIZE > 3'd2) || (S_AXI_AWBURST == 2'b11) ||
                   ((S_AXI_AWBURST == 2'b10) && !(S_AXI_AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));
        beat_err = (S_AXI_WID[ID_W-1:0] != id) || (S_AXI_WLAST != last_beat);
`else
        aw_err   = 1'b0;
        beat_err = 1'b0;
`endif
        // once a burst is flagged, the offending beat and all later ones are dropped
        we = beat_fire && !err && !beat_err && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= 2'b00;
            err           <= 1'b0;
            id            <= '0;
            burst         <= 2'b00;
            len           <= 4'd0;
            size          <= 3'd0;
            addr          <= '0;
            beat_cnt      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        id            <= S_AXI_AWID;
                        burst         <= S_AXI_AWBURST;
                        len           <= S_AXI_AWLEN;
                        size          <= S_AXI_AWSIZE;
                        addr          <= S_AXI_AWADDR[AW-1:0];
                        beat_cnt      <= 4'd0;
                        err           <= aw_err;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        addr     <= addr_nxt;
                        beat_cnt <= beat_cnt + 4'd1;
                        err      <= err | beat_err;
                        if (last_beat) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BID    <= id;
                            S_AXI_BRESP  <= (err || beat_err) ? 2'b10 : 2'b00;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // memory is deliberately not reset; reads see the pre-write word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[addr[AW-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) dbg_data <= 32'd0;
        else       dbg_data <= mem[dbg_addr];
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWADDR[31:AW],
                         S_AXI_WID, S_AXI_WLAST};
endmodule

// File: tb/tb_axi3_wr_slave_mem.sv
// Directed bench for axi3_wr_slave_mem: burst addressing, strobes, B backpressure, mid-burst reset.
module tb_axi3_wr_slave_mem;
    localparam int ID_W = 4, MEM_AW = 8;

    logic clk = 0, reset = 1;
    logic [31:0] awaddr = 0; logic [ID_W-1:0] awid = 0; logic [1:0] awburst = 0;
    logic [3:0] awlen = 0; logic [2:0] awsize = 0; logic awvalid = 0;
    logic awready, wready, bvalid;
    logic [6:0] wid = 0; logic [31:0] wdata = 0; logic [3:0] wstrb = 0;
    logic wlast = 0, wvalid = 0, bready = 0;
    logic [ID_W-1:0] bid; logic [1:0] bresp;
    logic [MEM_AW-1:0] dbg_addr = 0; logic [31:0] dbg_data;

    int total = 0, bad = 0;
    logic [31:0] rv;

    always #5 clk = ~clk;

    axi3_wr_slave_mem #(.ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWBURST(awburst),
        .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWLOCK(2'b00),
        .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WID(wid), .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // all tasks start and end at posedge+1
    task automatic send_aw(input logic [ID_W-1:0] i, input logic [31:0] a, input logic [1:0] b,
                           input logic [3:0] l, input logic [2:0] s);
        bit ok = 0;
        awid = i; awaddr = a; awburst = b; awlen = l; awsize = s; awvalid = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (awready) ok = 1;
            @(posedge clk); #1;
        end
        awvalid = 0;
        if (!ok) chk("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic [6:0] w, input logic l);
        bit ok = 0;
        wdata = d; wstrb = st; wid = w; wlast = l; wvalid = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (wready) ok = 1;
            @(posedge clk); #1;
        end
        wvalid = 0;
        if (!ok) chk("w_timeout", 0, 1);
    endtask

    task automatic take_b(input string tag, input logic [ID_W-1:0] eid, input logic [1:0] eresp);
        bit ok = 0;
        bready = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bvalid) begin
                ok = 1;
                chk({tag, "_bid"}, 32'(bid), 32'(eid));
                chk({tag, "_bresp"}, 32'(bresp), 32'(eresp));
            end
            @(posedge clk); #1;
        end
        bready = 0;
        if (!ok) chk({tag, "_b_timeout"}, 0, 1);
    endtask

    task automatic rd(input logic [MEM_AW-1:0] a, output logic [31:0] d);
        dbg_addr = a;
        tick();
        d = dbg_data;
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        send_aw(4'h0, a, 2'b01, 4'd0, 3'd2);
        send_w(d, 4'hF, 7'h0, 1'b1);
        take_b("init", 4'h0, 2'b00);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_bid", 32'(bid), 0);
        chk("rst_bresp", 32'(bresp), 0);
        chk("rst_dbg", dbg_data, 0);
        reset = 0;
        chk("rel_awready0", 32'(awready), 0);
        tick();
        chk("rel_awready1", 32'(awready), 1);

        // 1: single INCR beat
        send_aw(4'hA, 32'h10, 2'b01, 4'd0, 3'd2);
        chk("t1_wready", 32'(wready), 1);
        chk("t1_awready", 32'(awready), 0);
        send_w(32'hDEADBEEF, 4'hF, 7'h0A, 1'b1);
        chk("t1_bvalid", 32'(bvalid), 1);
        chk("t1_wready_off", 32'(wready), 0);
        take_b("t1", 4'hA, 2'b00);
        chk("t1_awready_back", 32'(awready), 1);
        rd(8'd4, rv); chk("t1_mem4", rv, 32'hDEADBEEF);

        // 2: INCR LEN=3 with gapped WVALID
        send_aw(4'h3, 32'h20, 2'b01, 4'd3, 3'd2);
        for (int k = 1; k <= 4; k++) begin
            send_w(32'(k), 4'hF, 7'h03, k == 4);
            if (k < 4) tick();
        end
        take_b("t2", 4'h3, 2'b00);
        begin
            int extra = 0;
            for (int n = 0; n < 5; n++) begin tick(); if (bvalid) extra++; end
            chk("t2_one_b", 32'(extra), 0);
        end
        for (int k = 0; k < 4; k++) begin
            rd(8'(8 + k), rv); chk("t2_mem", rv, 32'(k + 1));
        end

        // 3: WRAP LEN=3 from 0x38 -> words 14,15,12,13
        send_aw(4'h5, 32'h38, 2'b10, 4'd3, 3'd2);
        send_w(32'hA, 4'hF, 7'h05, 0);
        send_w(32'hB, 4'hF, 7'h05, 0);
        send_w(32'hC, 4'hF, 7'h05, 0);
        send_w(32'hD, 4'hF, 7'h05, 1);
        take_b("t3", 4'h5, 2'b00);
        rd(8'd14, rv); chk("t3_mem14", rv, 32'hA);
        rd(8'd15, rv); chk("t3_mem15", rv, 32'hB);
        rd(8'd12, rv); chk("t3_mem12", rv, 32'hC);
        rd(8'd13, rv); chk("t3_mem13", rv, 32'hD);

        // 4: FIXED LEN=1 with byte strobes
        wr_word(32'h0, 32'h0);
        send_aw(4'h1, 32'h0, 2'b00, 4'd1, 3'd2);
        send_w(32'h00000011, 4'h1, 7'h01, 0);
        send_w(32'h44000000, 4'h8, 7'h01, 1);
        take_b("t4", 4'h1, 2'b00);
        rd(8'd0, rv); chk("t4_mem0", rv, 32'h44000011);

        // 5: B backpressure
        send_aw(4'h7, 32'h60, 2'b01, 4'd0, 3'd2);
        send_w(32'h55AA55AA, 4'hF, 7'h07, 1);
        begin
            int bad_hold = 0;
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                if (!bvalid || bid !== 4'h7 || bresp !== 2'b00 || awready) bad_hold++;
                @(posedge clk); #1;
            end
            chk("t5_hold", 32'(bad_hold), 0);
        end
        take_b("t5", 4'h7, 2'b00);
        chk("t5_awready", 32'(awready), 1);
        rd(8'd24, rv); chk("t5_mem24", rv, 32'h55AA55AA);

`ifdef AXI3_WR_SLAVE_CHK_EN
        // 6a: illegal AWSIZE -> SLVERR, no write
        wr_word(32'h40, 32'h12345678);
        send_aw(4'h2, 32'h40, 2'b01, 4'd0, 3'd3);
        send_w(32'hFFFFFFFF, 4'hF, 7'h02, 1);
        take_b("t6_size", 4'h2, 2'b10);
        rd(8'd16, rv); chk("t6_mem16", rv, 32'h12345678);
`else
        // 6a: WID mismatch ignored
        send_aw(4'h5, 32'h44, 2'b01, 4'd0, 3'd2);
        send_w(32'hCAFEF00D, 4'hF, 7'h09, 1);
        take_b("t6_wid", 4'h5, 2'b00);
        rd(8'd17, rv); chk("t6_mem17", rv, 32'hCAFEF00D);
`endif

        // 6b: reset after beat 2 of 4
        send_aw(4'h4, 32'h80, 2'b01, 4'd3, 3'd2);
        send_w(32'h1111, 4'hF, 7'h04, 0);
        send_w(32'h2222, 4'hF, 7'h04, 0);
        reset = 1;
        tick();
        chk("t6_rst_bvalid", 32'(bvalid), 0);
        chk("t6_rst_awready", 32'(awready), 0);
        reset = 0;
        tick();
        chk("t6_rel_awready", 32'(awready), 1);
        chk("t6_rel_bvalid", 32'(bvalid), 0);
        rd(8'd32, rv); chk("t6_mem32", rv, 32'h1111);
        rd(8'd33, rv); chk("t6_mem33", rv, 32'h2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
